fifo_ram_ctrl: RTL and testbench

- Controller side of the FIFO's storage RAM: owns write/read pointers and drives the RAM write and read ports.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer, giving first-word-fall-through valid/ready streams upstream and downstream.
- Sits between the FIFO's producer/consumer interfaces and the dual-address RAM instance.

---
 rtl/fifo_ram_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_ram_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
// Storage-RAM controller for a first-word-fall-through FIFO: owns the RAM pointers and
// hides the RAM's one-cycle read latency behind a two-entry output register buffer.
module fifo_ram_ctrl #(
  parameter int unsigned DLEN = 8,
  parameter int unsigned ALEN = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DLEN-1:0]   s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DLEN-1:0]   m_data,
  output logic              o_wen,
  output logic [ALEN-1:0]   o_waddr,
  output logic [DLEN-1:0]   o_wdata,
  output logic              o_ren,
  output logic [ALEN-1:0]   o_raddr,
  input  logic [DLEN-1:0]   i_rdata,
  output logic [ALEN+1:0]   o_count
);

  localparam int unsigned DEPTH = 2 ** ALEN;
  localparam int unsigned MCW   = ALEN + 1;
  localparam int unsigned CW    = ALEN + 2;

  logic [ALEN-1:0] wptr_q, wptr_d;
  logic [ALEN-1:0] rptr_q, rptr_d;
  logic [MCW-1:0]  mem_cnt_q, mem_cnt_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      obuf_cnt_q, obuf_cnt_d;
  logic [DLEN-1:0] obuf0_q, obuf0_d;
  logic [DLEN-1:0] obuf1_q, obuf1_d;

  logic            push;
  logic            pop;
  logic [2:0]      occ;
  logic [2:0]      room;
  logic [1:0]      tail_idx;

  // Handshakes and RAM port drive
  always_comb begin
    s_ready = rstn && (mem_cnt_q < MCW'(DEPTH));
    push    = s_valid && s_ready;
    m_valid = (obuf_cnt_q != 2'd0);
    pop     = m_valid && m_ready;

    o_wen   = push;
    o_waddr = wptr_q;
    o_wdata = s_data;

    // A read may issue only if its data will have a buffer slot when it lands,
    // counting the slot freed by a pop this cycle.
    occ     = 3'(obuf_cnt_q) + 3'(inflight_q);
    room    = 3'd2 + 3'(pop);
    o_ren   = (mem_cnt_q != '0) && (occ < room);
    o_raddr = rptr_q;

    m_data  = obuf0_q;
    o_count = CW'(mem_cnt_q) + CW'(inflight_q) + CW'(obuf_cnt_q);
  end

  // Pointer, RAM occupancy and in-flight tracking
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = o_ren;
    mem_cnt_d  = mem_cnt_q + MCW'(push) - MCW'(o_ren);
    if (push) begin
      wptr_d = wptr_q + ALEN'(1);
    end
    if (o_ren) begin
      rptr_d = rptr_q + ALEN'(1);
    end
  end

  // Output buffer: pop shifts the head out, returning read data lands behind what remains
  always_comb begin
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;
    obuf_cnt_d = obuf_cnt_q - 2'(pop) + 2'(inflight_q);
    tail_idx   = obuf_cnt_q - 2'(pop);
    if (pop) begin
      obuf0_d = obuf1_q;
    end
    if (inflight_q) begin
      if (tail_idx == 2'd0) begin
        obuf0_d = i_rdata;
      end else begin
        obuf1_d = i_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      obuf_cnt_q <= 2'd0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural RAM, queue-based scoreboard monitor,
// directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_fifo_ram_ctrl;

  localparam int unsigned DLEN  = 8;
  localparam int unsigned ALEN  = 2;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid;
  logic            s_ready;
  logic [DLEN-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DLEN-1:0] m_data;
  logic            o_wen;
  logic [ALEN-1:0] o_waddr;
  logic [DLEN-1:0] o_wdata;
  logic            o_ren;
  logic [ALEN-1:0] o_raddr;
  logic [DLEN-1:0] i_rdata;
  logic [ALEN+1:0] o_count;

  always #5 clk = ~clk;

  fifo_ram_ctrl #(.DLEN(DLEN), .ALEN(ALEN)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_ren(o_ren), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .o_count(o_count)
  );

  // RAM with one-cycle registered read
  logic [DLEN-1:0] ram [DEPTH];
  logic [DLEN-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (o_wen) ram[o_waddr] <= o_wdata;
    if (o_ren) rdata_q <= ram[o_raddr];
  end
  assign i_rdata = rdata_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted words plus counts of RAM writes/reads
  logic [DLEN-1:0] exp_q[$];
  int unsigned     n_push_m = 0;
  int unsigned     n_read_m = 0;
  logic            hold_q   = 1'b0;
  logic [DLEN-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      n_push_m = 0;
      n_read_m = 0;
      hold_q   = 1'b0;
    end else begin
      chk("count", 32'(o_count), 32'(exp_q.size()));
      chk("s_ready_rule", 32'(s_ready), 32'((n_push_m - n_read_m) < DEPTH));
      if (exp_q.size() == 0) chk("empty_no_valid", 32'(m_valid), 32'd0);
      if (hold_q) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(hold_data));
      end
      chk("wen", 32'(o_wen), 32'(s_valid && s_ready));
      if (o_ren) begin
        chk("ren_has_data", 32'(n_push_m != n_read_m), 32'd1);
        chk("raddr", 32'(o_raddr), n_read_m % DEPTH);
        n_read_m++;
      end
      if (s_valid && s_ready) begin
        chk("waddr", 32'(o_waddr), n_push_m % DEPTH);
        chk("wdata", 32'(o_wdata), 32'(s_data));
        exp_q.push_back(s_data);
        n_push_m++;
      end
      if (m_valid && m_ready) begin
        chk("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hold_q    = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  int n_acc;
  int n_push;
  int n_pop;
  int waited;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_wen", 32'(o_wen), 32'd0);
    chk("rst_ren", 32'(o_ren), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single word latency
    step(); s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk);
    chk("t1_wen_c0", 32'(o_wen), 32'd1);
    chk("t1_waddr_c0", 32'(o_waddr), 32'd0);
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("t1_ren_c1", 32'(o_ren), 32'd1);
    chk("t1_raddr_c1", 32'(o_raddr), 32'd0);
    chk("t1_valid_c1", 32'(m_valid), 32'd0);
    step(); @(negedge clk);
    chk("t1_valid_c2", 32'(m_valid), 32'd0);
    step(); @(negedge clk);
    chk("t1_valid_c3", 32'(m_valid), 32'd1);
    chk("t1_data_c3", 32'(m_data), 32'hA5);
    step(); @(negedge clk);
    chk("t1_count_after", 32'(o_count), 32'd0);

    // Fill to capacity with consumer stalled
    n_acc = 0;
    for (int i = 1; i <= 7; i++) begin
      step(); m_ready = 1'b0; s_valid = 1'b1; s_data = DLEN'(i);
      @(negedge clk);
      chk("t2_s_ready", 32'(s_ready), (i < 7) ? 32'd1 : 32'd0);
      if (s_valid && s_ready) n_acc++;
    end
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("t2_accepted", 32'(n_acc), 32'd6);
    chk("t2_count", 32'(o_count), 32'd6);
    chk("t2_valid", 32'(m_valid), 32'd1);
    chk("t2_head", 32'(m_data), 32'h01);

    // Drain with no bubbles
    step(); m_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t3_valid", 32'(m_valid), 32'd1);
      chk("t3_data", 32'(m_data), 32'(k));
      step();
    end
    @(negedge clk);
    chk("t3_empty_valid", 32'(m_valid), 32'd0);
    chk("t3_empty_count", 32'(o_count), 32'd0);

    // Streaming
    step();
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = DLEN'(i); m_ready = 1'b1;
      @(negedge clk);
      chk("t4_s_ready", 32'(s_ready), 32'd1);
      if (i >= 3) begin
        chk("t4_valid", 32'(m_valid), 32'd1);
        chk("t4_count_le3", 32'(o_count <= 3), 32'd1);
      end
      step();
    end
    s_valid = 1'b0;
    drain("t4_drain");

    // Random traffic
    n_push = 0; n_pop = 0;
    for (int c = 0; c < 20000 && n_pop < 1000; c++) begin
      step();
      s_valid = (n_push < 1000) && ($urandom_range(0, 1) == 1);
      s_data  = DLEN'($urandom);
      m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_valid && s_ready) n_push++;
      if (m_valid && m_ready) n_pop++;
    end
    chk("t5_pops", 32'(n_pop), 32'd1000);
    step(); s_valid = 1'b0; m_ready = 1'b1;
    drain("t5_drain");

    // Asynchronous reset with four entries held
    for (int i = 0; i < 4; i++) begin
      step(); m_ready = 1'b0; s_valid = 1'b1; s_data = DLEN'(8'h50 + i);
      @(negedge clk);
    end
    step(); s_valid = 1'b0;
    @(negedge clk);
    chk("t6_count_pre", 32'(o_count), 32'd4);
    step(); s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("t6_s_ready", 32'(s_ready), 32'd0);
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_wen", 32'(o_wen), 32'd0);
    chk("t6_ren", 32'(o_ren), 32'd0);
    chk("t6_count", 32'(o_count), 32'd0);
    s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    step(); s_valid = 1'b1; s_data = 8'h3C;
    step(); s_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!m_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("t6_post_valid", 32'(m_valid), 32'd1);
    chk("t6_post_data", 32'(m_data), 32'h3C);
    step(); m_ready = 1'b1;
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
